// File: rtl/tick_edge_rx_pkg.sv
// -----------------------------------------------------------------------------
// tick_edge_rx_pkg
// Shared definitions for the slow update-tick receiver:
//   - rx_state_e : receiver FSM state encoding
//   - in_window  : inclusive range test used for period qualification
// Optional feature macro used by this slice: TICK_RX_GLITCH_EN (see tick_edge_rx_sync).
// -----------------------------------------------------------------------------
package tick_edge_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEEK    = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_LOST    = 3'd4
    } rx_state_e;

    // Inclusive window test. Bounds are signed so a tolerance larger than the
    // nominal period still gives a sensible (open-ended) lower bound.
    function automatic logic in_window(input int unsigned val, input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) <= hi);
    endfunction

endpackage

// File: rtl/tick_edge_rx_sync.sv
// -----------------------------------------------------------------------------
// tick_edge_rx_sync
// Brings the asynchronous slow square wave into the clk domain and produces a
// single-cycle rising-edge indication.
//   clk     in  fast system clock
//   rst     in  asynchronous, active-high reset
//   tick_i  in  slow square wave, asynchronous to clk
//   rise_o  out combinational, high for one cycle per rising edge of the
//               (optionally filtered) synchronised level
// Configuration macro TICK_RX_GLITCH_EN: when defined, the synchronised level
// must be stable for GLITCH_CYC cycles before the filtered level follows it.
// When undefined there is no filter and GLITCH_CYC has no effect.
// -----------------------------------------------------------------------------
module tick_edge_rx_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_CYC  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    output logic rise_o
);

    if (SYNC_STAGES < 2 || GLITCH_CYC < 1) begin : g_cfg_check
        $error("tick_edge_rx_sync: need SYNC_STAGES >= 2 and GLITCH_CYC >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_i};
        end
    end

`ifdef TICK_RX_GLITCH_EN
    localparam int GW = (GLITCH_CYC > 2) ? $clog2(GLITCH_CYC) : 1;

    logic          filt_q;
    logic [GW-1:0] stab_q;

    // stab_q counts consecutive cycles the synced level disagrees with the
    // filtered level; any agreement restarts the count, so short pulses die.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            stab_q <= '0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            stab_q <= '0;
        end else if (stab_q == GW'(GLITCH_CYC - 1)) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            stab_q <= '0;
        end else begin
            stab_q <= stab_q + 1'b1;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_o = level & ~prev_q;

endmodule

// File: rtl/tick_edge_rx.sv
// -----------------------------------------------------------------------------
// tick_edge_rx
// Receiving end of the slow divided update clock. Emits a one-cycle update
// strobe per rising edge of tick_in, measures the rising-to-rising period and
// tracks lock against the nominal period NOM = 2*EXP_HALF (+/- TOL).
//   clk      in  fast system clock
//   rst      in  asynchronous, active-high reset
//   en       in  receiver enable; low forces IDLE
//   tick_in  in  slow square wave, asynchronous to clk
//   upd_stb  out one-cycle pulse per accepted rising edge
//   period   out last measured period in clk cycles (saturating)
//   locked   out LOCK_CNT consecutive good periods, no fault since
//   lost     out timeout or bad period after lock / during measurement
// Configuration macro TICK_RX_GLITCH_EN enables the input glitch filter in
// tick_edge_rx_sync (adds GLITCH_CYC cycles of strobe latency).
// -----------------------------------------------------------------------------
module tick_edge_rx
    import tick_edge_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 26,
    parameter int EXP_HALF    = 2500000,
    parameter int TOL         = 1024,
    parameter int LOCK_CNT    = 2,
    parameter int GLITCH_CYC  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick_in,
    output logic             upd_stb,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             lost
);

    localparam int NOM    = 2 * EXP_HALF;
    localparam int GOOD_LO = NOM - TOL;
    localparam int GOOD_HI = NOM + TOL;
    localparam int TO_CYC  = NOM + TOL + 1;
    localparam int GC_W    = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TO_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rx_state_e        state_q;
    logic [GC_W-1:0]  good_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise;
    logic             good;
    logic             timeout;

    tick_edge_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .GLITCH_CYC  (GLITCH_CYC)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .tick_i (tick_in),
        .rise_o (rise)
    );

    // cnt_q holds the number of cycles since the last edge, counting the edge
    // cycle itself as 1, so at the next edge it equals the full period.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign good    = in_window(32'(cnt_q), GOOD_LO, GOOD_HI);
    assign timeout = (cnt_q == TO_C);

    // Edge handling takes priority over timeout in every state, so an edge
    // landing exactly on the timeout count is judged as a (bad) period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            good_cnt_q <= '0;
            upd_stb    <= 1'b0;
            period     <= '0;
            locked     <= 1'b0;
            lost       <= 1'b0;
        end else begin
            upd_stb <= 1'b0;
            if (!en) begin
                state_q    <= ST_IDLE;
                good_cnt_q <= '0;
                locked     <= 1'b0;
                lost       <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SEEK;
                    end
                    ST_SEEK: begin
                        // First edge only arms the measurement; period is kept.
                        if (rise) begin
                            upd_stb    <= 1'b1;
                            state_q    <= ST_MEASURE;
                            good_cnt_q <= '0;
                        end
                    end
                    ST_MEASURE: begin
                        if (rise) begin
                            upd_stb <= 1'b1;
                            period  <= cnt_q;
                            if (good) begin
                                good_cnt_q <= good_cnt_q + 1'b1;
                                if (good_cnt_q == GC_W'(LOCK_CNT - 1)) begin
                                    state_q <= ST_LOCKED;
                                    locked  <= 1'b1;
                                end
                            end else begin
                                good_cnt_q <= '0;
                            end
                        end else if (timeout) begin
                            state_q <= ST_LOST;
                            lost    <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (rise) begin
                            upd_stb <= 1'b1;
                            period  <= cnt_q;
                            if (!good) begin
                                state_q <= ST_LOST;
                                locked  <= 1'b0;
                                lost    <= 1'b1;
                            end
                        end else if (timeout) begin
                            state_q <= ST_LOST;
                            locked  <= 1'b0;
                            lost    <= 1'b1;
                        end
                    end
                    ST_LOST: begin
                        if (rise) begin
                            upd_stb    <= 1'b1;
                            period     <= cnt_q;
                            state_q    <= ST_MEASURE;
                            good_cnt_q <= '0;
                            lost       <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_edge_rx.sv
module tb_tick_edge_rx;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int EXP_HALF    = 10;
    localparam int TOL         = 2;
    localparam int LOCK_CNT    = 2;
    localparam int GLITCH_CYC  = 4;
    localparam int NOM         = 2 * EXP_HALF;
    localparam int TO          = NOM + TOL + 1;
    localparam int PMAX        = (1 << CNT_W) - 1;
`ifdef TICK_RX_GLITCH_EN
    localparam int LAT         = SYNC_STAGES + GLITCH_CYC + 1;
    localparam int GLITCH_STB  = 0;
`else
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int GLITCH_STB  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             tick_in;
    logic             upd_stb;
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             lost;

    int n_chk  = 0;
    int n_fail = 0;

    tick_edge_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .EXP_HALF    (EXP_HALF),
        .TOL         (TOL),
        .LOCK_CNT    (LOCK_CNT),
        .GLITCH_CYC  (GLITCH_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .tick_in (tick_in),
        .upd_stb (upd_stb),
        .period  (period),
        .locked  (locked),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int gap;
        int exp_p;
        bit exp_lk;
        bit exp_ls;
    } vec_t;

    typedef enum {M_SEEK, M_MEAS, M_LOCK, M_LOST} mst_t;

    vec_t tbl[19];

    function automatic vec_t mk(input int g, input int p, input bit lk, input bit ls);
        vec_t v;
        v.gap    = g;
        v.exp_p  = p;
        v.exp_lk = lk;
        v.exp_ls = ls;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock later, sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise tick_in now, keep it high for g/2 cycles, low for the rest of g.
    // The strobe for this rise is checked LAT cycles in, together with the
    // outputs it should have updated; any other strobe in the window is extra.
    task automatic run_gap(input int g, input bit exp_stb, input int exp_p,
                           input bit exp_lk, input bit exp_ls, input string nm);
        int extra;
        extra   = 0;
        tick_in = 1'b1;
        for (int k = 1; k <= g; k++) begin
            step();
            if (k == LAT) begin
                chk({nm, ".stb"},    32'(upd_stb), 32'(exp_stb));
                chk({nm, ".period"}, 32'(period),  32'(exp_p));
                chk({nm, ".locked"}, 32'(locked),  32'(exp_lk));
                chk({nm, ".lost"},   32'(lost),    32'(exp_ls));
            end else if (upd_stb === 1'b1) begin
                extra++;
            end
            if (k == g / 2) tick_in = 1'b0;
        end
        chk({nm, ".extra"}, 32'(extra), 32'd0);
    endtask

    task automatic hold_low(input int n, input string nm);
        int stb;
        stb = 0;
        for (int j = 1; j <= n; j++) begin
            step();
            if (upd_stb === 1'b1) stb++;
        end
        chk({nm, ".nostb"}, 32'(stb), 32'd0);
    endtask

    initial begin
        int   stb;
        int   g;
        int   r;
        int   prevg;
        int   mgc;
        int   mper;
        bit   good;
        mst_t mst;

        tbl[0]  = mk(20,  0, 0, 0);
        tbl[1]  = mk(20, 20, 0, 0);
        tbl[2]  = mk(22, 20, 1, 0);
        tbl[3]  = mk(18, 22, 1, 0);
        tbl[4]  = mk(17, 18, 1, 0);
        tbl[5]  = mk(20, 17, 0, 1);
        tbl[6]  = mk(23, 20, 0, 0);
        tbl[7]  = mk(20, 23, 0, 0);
        tbl[8]  = mk(20, 20, 0, 0);
        tbl[9]  = mk(20, 20, 1, 0);
        tbl[10] = mk(24, 20, 1, 0);
        tbl[11] = mk(20, 24, 0, 0);
        tbl[12] = mk(20, 20, 0, 0);
        tbl[13] = mk(20, 20, 1, 0);
        tbl[14] = mk(15, 20, 1, 0);
        tbl[15] = mk(20, 15, 0, 1);
        tbl[16] = mk(20, 20, 0, 0);
        tbl[17] = mk(20, 20, 0, 0);
        tbl[18] = mk(20, 20, 1, 0);

        rst     = 1'b1;
        en      = 1'b0;
        tick_in = 1'b0;
        repeat (3) step();
        chk("reset.upd_stb", 32'(upd_stb), 32'd0);
        chk("reset.period",  32'(period),  32'd0);
        chk("reset.locked",  32'(locked),  32'd0);
        chk("reset.lost",    32'(lost),    32'd0);
        rst = 1'b0;
        repeat (2) step();
        en = 1'b1;
        repeat (5) step();

        // Lock-up, window boundaries, edge-at-timeout, timeout-then-edge, short period.
        for (int i = 0; i < 19; i++) begin
            run_gap(tbl[i].gap, 1'b1, tbl[i].exp_p, tbl[i].exp_lk, tbl[i].exp_ls,
                    $sformatf("tbl%0d", i));
        end

        // Locked, tick held low: loss exactly TO cycles after the last edge.
        stb = 0;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (upd_stb === 1'b1) stb++;
            if (j == LAT + TO - NOM - 1) begin
                chk("timeout.pre.lost",   32'(lost),   32'd0);
                chk("timeout.pre.locked", 32'(locked), 32'd1);
            end
            if (j == LAT + TO - NOM) begin
                chk("timeout.lost",   32'(lost),   32'd1);
                chk("timeout.locked", 32'(locked), 32'd0);
            end
        end
        chk("timeout.nostb", 32'(stb), 32'd0);
        run_gap(20, 1'b1, 60, 1'b0, 1'b0, "relock0");
        run_gap(20, 1'b1, 20, 1'b0, 1'b0, "relock1");
        run_gap(20, 1'b1, 20, 1'b1, 1'b0, "relock2");

        // Period counter saturation.
        hold_low(280, "sathold");
        chk("sathold.lost", 32'(lost), 32'd1);
        run_gap(20, 1'b1, PMAX, 1'b0, 1'b0, "sat0");
        run_gap(20, 1'b1, 20,   1'b0, 1'b0, "sat1");
        run_gap(20, 1'b1, 20,   1'b1, 1'b0, "sat2");

        // Enable drop while locked.
        en = 1'b0;
        step();
        chk("endrop.locked",  32'(locked),  32'd0);
        chk("endrop.lost",    32'(lost),    32'd0);
        chk("endrop.period",  32'(period),  32'd20);
        chk("endrop.upd_stb", 32'(upd_stb), 32'd0);
        run_gap(20, 1'b0, 20, 1'b0, 1'b0, "idle0");
        run_gap(20, 1'b0, 20, 1'b0, 1'b0, "idle1");

        // Re-enable: first edge keeps the held period.
        en = 1'b1;
        run_gap(20, 1'b1, 20, 1'b0, 1'b0, "reen0");
        run_gap(20, 1'b1, 20, 1'b0, 1'b0, "reen1");
        run_gap(20, 1'b1, 20, 1'b1, 1'b0, "reen2");

        // Asynchronous reset while a strobe is being presented.
        tick_in = 1'b1;
        repeat (LAT) step();
        chk("rstmid.pre_stb", 32'(upd_stb), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.upd_stb", 32'(upd_stb), 32'd0);
        chk("rstmid.period",  32'(period),  32'd0);
        chk("rstmid.locked",  32'(locked),  32'd0);
        chk("rstmid.lost",    32'(lost),    32'd0);
        tick_in = 1'b0;
        repeat (5) step();
        rst = 1'b0;
        repeat (3) step();

        // Two-cycle glitch while seeking.
        tick_in = 1'b1;
        repeat (2) step();
        tick_in = 1'b0;
        stb = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (upd_stb === 1'b1) stb++;
        end
        chk("glitch.stb_count", 32'(stb), 32'(GLITCH_STB));
        chk("glitch.period",    32'(period), 32'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();

        // Randomised gaps against an edge-level model of the receiver rules.
        mst   = M_SEEK;
        mgc   = 0;
        mper  = 0;
        prevg = 0;
        for (int i = 0; i < 50; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       g = int'($urandom_range(NOM - TOL, NOM + TOL));
            else if (r < 8)  g = int'($urandom_range(15, 25));
            else if (r == 8) g = int'($urandom_range(24, 60));
            else             g = int'($urandom_range(250, 320));

            if (mst == M_SEEK) begin
                mst = M_MEAS;
                mgc = 0;
            end else begin
                if ((mst == M_MEAS || mst == M_LOCK) && prevg > TO) mst = M_LOST;
                mper = (prevg > PMAX) ? PMAX : prevg;
                good = (prevg >= NOM - TOL) && (prevg <= NOM + TOL);
                case (mst)
                    M_MEAS: begin
                        if (good) begin
                            mgc++;
                            if (mgc >= LOCK_CNT) mst = M_LOCK;
                        end else begin
                            mgc = 0;
                        end
                    end
                    M_LOCK: if (!good) mst = M_LOST;
                    M_LOST: begin
                        mst = M_MEAS;
                        mgc = 0;
                    end
                    default: ;
                endcase
            end
            run_gap(g, 1'b1, mper, mst == M_LOCK, mst == M_LOST, $sformatf("rnd%0d", i));
            prevg = g;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
